// File: rtl/ps2_mouse_apb.sv
// PS/2 mouse receiver with 3-byte packet assembly, packet FIFO and APB register access.
// Synchronous active-high reset; single clock domain; PS/2 lines are synchronised internally.
module ps2_mouse_apb #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [3:0]  paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        irq
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} rx_state_t;
    rx_state_t r_state, w_state_next;

    logic          r_c_s1, r_c_s2, r_c_prev, r_d_s1, r_d_s2;
    logic          w_fall;
    logic [7:0]    r_shift, r_byte, r_b0, r_x;
    logic [2:0]    r_bit_cnt;
    logic          r_par_ok, r_byte_valid, r_push;
    logic [TW-1:0] r_to_cnt;
    logic [1:0]    r_idx;
    logic [23:0]   r_pkt;
    logic          w_byte_ok, w_discard, w_perr_set, w_timeout;

    logic [23:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_full, w_not_empty, w_push_do, w_pop, w_ovf_set;

    logic          r_enable, r_irq_en, r_ovf, r_perr, r_irq;
    logic          w_access, w_wr, w_rd, w_flush, w_clr_ovf, w_clr_perr;
    logic          w_unused;

    // Lines idle high, so the synchronisers reset to 1 to avoid a spurious edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_c_s1   <= 1'b1;
            r_c_s2   <= 1'b1;
            r_c_prev <= 1'b1;
            r_d_s1   <= 1'b1;
            r_d_s2   <= 1'b1;
        end else begin
            r_c_s1   <= ps2_clk;
            r_c_s2   <= r_c_s1;
            r_c_prev <= r_c_s2;
            r_d_s1   <= ps2_data;
            r_d_s2   <= r_d_s1;
        end
    end

    assign w_fall    = r_c_prev & ~r_c_s2;
    assign w_timeout = (r_state != S_IDLE) && !w_fall && (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_byte_ok    = 1'b0;
        w_discard    = 1'b0;
        w_perr_set   = 1'b0;
        if (!r_enable || w_timeout) begin
            w_state_next = S_IDLE;
        end else if (w_fall) begin
            case (r_state)
                S_IDLE:   if (!r_d_s2) w_state_next = S_DATA;
                S_DATA:   if (r_bit_cnt == 3'd7) w_state_next = S_PARITY;
                S_PARITY: begin
                    w_state_next = S_STOP;
                    w_perr_set   = ~(^{r_shift, r_d_s2});
                end
                S_STOP: begin
                    w_state_next = S_IDLE;
                    if (r_d_s2 && r_par_ok) begin
                        w_byte_ok = 1'b1;
                    end else begin
                        w_discard  = 1'b1;
                        w_perr_set = ~r_d_s2;
                    end
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_par_ok     <= 1'b0;
            r_to_cnt     <= '0;
            r_byte_valid <= 1'b0;
            r_byte       <= '0;
        end else begin
            r_byte_valid <= w_byte_ok;
            if (w_byte_ok) r_byte <= r_shift;
            if (!r_enable || r_state == S_IDLE || w_fall || w_timeout) r_to_cnt <= '0;
            else                                                      r_to_cnt <= r_to_cnt + TW'(1);
            if (w_fall) begin
                case (r_state)
                    S_IDLE:   r_bit_cnt <= '0;
                    S_DATA: begin
                        r_shift   <= {r_d_s2, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                    end
                    S_PARITY: r_par_ok <= ^{r_shift, r_d_s2};
                    default:  ;
                endcase
            end
        end
    end

    // Byte 0 must carry the sync bit (bit 3); otherwise stay waiting for a header.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx  <= 2'd0;
            r_b0   <= '0;
            r_x    <= '0;
            r_push <= 1'b0;
            r_pkt  <= '0;
        end else begin
            r_push <= 1'b0;
            if (!r_enable || w_timeout || w_discard) begin
                r_idx <= 2'd0;
            end else if (r_byte_valid) begin
                case (r_idx)
                    2'd0: if (r_byte[3]) begin
                        r_b0  <= r_byte;
                        r_idx <= 2'd1;
                    end
                    2'd1: begin
                        r_x   <= r_byte;
                        r_idx <= 2'd2;
                    end
                    default: begin
                        r_pkt  <= {r_byte, r_x, r_b0};
                        r_push <= 1'b1;
                        r_idx  <= 2'd0;
                    end
                endcase
            end
        end
    end

    assign w_access    = psel & penable;
    assign w_wr        = w_access & pwrite;
    assign w_rd        = w_access & ~pwrite;
    assign w_flush     = w_wr && (paddr[3:2] == 2'd3) && pwdata[2];
    assign w_clr_ovf   = w_wr && (paddr[3:2] == 2'd3) && pwdata[0];
    assign w_clr_perr  = w_wr && (paddr[3:2] == 2'd3) && pwdata[1];
    assign w_full      = (r_count == CW'(FIFO_DEPTH));
    assign w_not_empty = (r_count != '0);
    assign w_pop       = w_rd && (paddr[3:2] == 2'd1) && w_not_empty && !w_flush;
    assign w_push_do   = r_push && !w_flush && (!w_full || w_pop);
    assign w_ovf_set   = r_push && !w_flush && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_push_do) r_mem[r_wr_ptr] <= r_pkt;
    end

    always_ff @(posedge clk) begin
        if (reset || w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_do) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)     r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(w_push_do) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_enable <= 1'b0;
            r_irq_en <= 1'b0;
            r_ovf    <= 1'b0;
            r_perr   <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if (w_wr && paddr[3:2] == 2'd2) {r_irq_en, r_enable} <= pwdata[1:0];
            if (w_ovf_set)       r_ovf <= 1'b1;
            else if (w_clr_ovf)  r_ovf <= 1'b0;
            if (w_perr_set)      r_perr <= 1'b1;
            else if (w_clr_perr) r_perr <= 1'b0;
            r_irq <= r_irq_en & (w_not_empty | r_ovf);
        end
    end

    always_comb begin
        prdata = '0;
        if (w_rd) begin
            case (paddr[3:2])
                2'd0: begin
                    prdata[0]    = w_not_empty;
                    prdata[1]    = w_full;
                    prdata[2]    = r_ovf;
                    prdata[3]    = r_perr;
                    prdata[11:8] = 4'(r_count);
                end
                2'd1:    if (w_not_empty) prdata[23:0] = r_mem[r_rd_ptr];
                2'd2:    prdata[1:0] = {r_irq_en, r_enable};
                default: ;
            endcase
        end
    end

    assign pready   = 1'b1;
    assign irq      = r_irq;
    assign w_unused = ^{pwdata[31:3], paddr[1:0]};
endmodule

// File: tb/tb_ps2_mouse_apb.sv
// Bench for ps2_mouse_apb: directed scenarios then random bytes, checked against a packet-level queue model.
module tb_ps2_mouse_apb;
    localparam int DEPTH = 4;
    localparam int TO    = 300;
    localparam int HALF  = 8;

    logic        clk = 1'b0;
    logic        reset, ps2_clk, ps2_data, psel, penable, pwrite;
    logic [3:0]  paddr;
    logic [31:0] pwdata, prdata;
    logic        pready, irq;

    int errors = 0;
    int checks = 0;

    logic [23:0] m_q[$];
    bit          m_ovf, m_perr, m_irq_en;
    int          m_idx;
    logic [7:0]  m_b0, m_x;

    always #5 clk = ~clk;

    ps2_mouse_apb #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .prdata(prdata), .pready(pready), .irq(irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Packet-level model: a byte either completes cleanly or is lost with a parity/framing error.
    function automatic void m_byte(input logic [7:0] b, input bit good);
        if (!good) begin
            m_perr = 1'b1;
            m_idx  = 0;
        end else if (m_idx == 0) begin
            if (b[3]) begin m_b0 = b; m_idx = 1; end
        end else if (m_idx == 1) begin
            m_x = b; m_idx = 2;
        end else begin
            m_idx = 0;
            if (m_q.size() == DEPTH) m_ovf = 1'b1;
            else                     m_q.push_back({b, m_x, m_b0});
        end
    endfunction

    function automatic logic [31:0] m_status();
        return {20'd0, 4'(m_q.size()), 4'd0, m_perr, m_ovf,
                (m_q.size() == DEPTH), (m_q.size() != 0)};
    endfunction

    task automatic ps2_bit(input logic b);
        @(negedge clk) ps2_data = b;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_head(input logic [7:0] b, input bit bad_par);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit((~^b) ^ bad_par);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        send_head(b, bad_par);
        ps2_bit(~bad_stop);
        repeat (4) @(negedge clk);
        m_byte(b, !bad_par && !bad_stop);
    endtask

    task automatic apb_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        psel = 1'b1; pwrite = 1'b1; paddr = a; pwdata = d; penable = 1'b0;
        @(negedge clk) penable = 1'b1;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk);
        psel = 1'b1; pwrite = 1'b0; paddr = a; penable = 1'b0;
        @(negedge clk) penable = 1'b1;
        #1 d = prdata;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic check_status(input string tag);
        logic [31:0] v;
        apb_read(4'h0, v);
        check(tag, v, m_status());
    endtask

    task automatic read_pkt(input string tag);
        logic [31:0] v, e;
        apb_read(4'h4, v);
        e = (m_q.size() != 0) ? {8'd0, m_q.pop_front()} : 32'd0;
        check(tag, v, e);
    endtask

    task automatic check_irq(input string tag);
        repeat (2) @(negedge clk);
        check(tag, {31'd0, irq}, {31'd0, m_irq_en && (m_q.size() != 0 || m_ovf)});
    endtask

    task automatic clear(input logic [2:0] v);
        apb_write(4'hC, {29'd0, v});
        if (v[0]) m_ovf = 1'b0;
        if (v[1]) m_perr = 1'b0;
        if (v[2]) m_q.delete();
    endtask

    task automatic send_triplet(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        send_byte(a, 1'b0, 1'b0);
        send_byte(b, 1'b0, 1'b0);
        send_byte(c, 1'b0, 1'b0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        logic [31:0] v;
        logic [7:0]  rb;
        bit          bp, bs;

        reset = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
        m_ovf = 0; m_perr = 0; m_irq_en = 0; m_idx = 0;
        repeat (4) @(negedge clk);
        reset = 1'b0;

        check("rst_prdata", prdata, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        apb_read(4'h0, v);
        check("rst_status", v, 32'd0);
        apb_read(4'h8, v);
        check("rst_ctrl", v, 32'd0);
        check("pready", {31'd0, pready}, 32'd1);

        apb_write(4'h8, 32'h3);
        m_irq_en = 1'b1;
        apb_read(4'h8, v);
        check("ctrl_rw", v, 32'h3);

        // Basic packet
        send_triplet(8'h08, 8'h05, 8'hFB);
        apb_read(4'h0, v);
        check("t1_status", v, 32'h101);
        check_irq("t1_irq_hi");
        apb_read(4'h4, v);
        check("t1_pkt", v, 32'h00FB0508);
        void'(m_q.pop_front());
        check_status("t1_status_empty");
        check_irq("t1_irq_lo");
        read_pkt("t1_read_empty");

        // Bad parity byte is dropped, triplet after it still assembles
        send_byte(8'h08, 1'b1, 1'b0);
        send_triplet(8'h09, 8'h01, 8'h02);
        apb_read(4'h0, v);
        check("t2_status", v, 32'h109);
        read_pkt("t2_pkt");
        check_status("t2_one_only");
        clear(3'b010);

        // Missing sync bit
        send_byte(8'h00, 1'b0, 1'b0);
        send_triplet(8'h08, 8'h10, 8'h20);
        check_status("t3_status");
        apb_read(4'h4, v);
        check("t3_pkt", v, 32'h00201008);
        void'(m_q.pop_front());
        check_status("t3_empty");

        // Overflow
        for (int i = 0; i < 5; i++) send_triplet(8'h08 | 8'(i), 8'(i + 1), 8'(i + 2));
        apb_read(4'h0, v);
        check("t4_status_full", v, 32'h407);
        check_irq("t4_irq");
        for (int i = 0; i < 4; i++) read_pkt($sformatf("t4_pkt%0d", i));
        check_status("t4_ovf_kept");
        clear(3'b001);
        check_status("t4_ovf_clr");
        check_irq("t4_irq_lo");

        // Timeout abandons the partial frame
        ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1);
        repeat (TO + 50) @(negedge clk);
        send_triplet(8'h08, 8'h01, 8'h01);
        apb_read(4'h0, v);
        check("t5_status", v, 32'h101);
        read_pkt("t5_pkt");

        // Pop coincides with push into a full FIFO
        for (int i = 0; i < 4; i++) send_triplet(8'h18, 8'(8'h40 + i), 8'(8'h50 + i));
        check_status("t6_full");
        send_byte(8'h28, 1'b0, 1'b0);
        send_byte(8'h7A, 1'b0, 1'b0);
        send_head(8'h7B, 1'b0);
        @(negedge clk) ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (3) @(negedge clk);
        psel = 1'b1; pwrite = 1'b0; paddr = 4'h4; penable = 1'b0;
        @(negedge clk) penable = 1'b1;
        #1 v = prdata;
        check("t6_pop_head", v, {8'd0, m_q.pop_front()});
        @(negedge clk);
        psel = 1'b0; penable = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
        m_byte(8'h7B, 1'b1);
        apb_read(4'h0, v);
        check("t6_status", v, 32'h403);
        for (int i = 0; i < 4; i++) read_pkt($sformatf("t6_pkt%0d", i));

        // Reset mid-frame with packets buffered
        send_triplet(8'h08, 8'h01, 8'h02);
        ps2_bit(1'b0); ps2_bit(1'b1);
        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        m_q.delete(); m_ovf = 0; m_perr = 0; m_idx = 0; m_irq_en = 0;
        check("mr_prdata", prdata, 32'd0);
        check("mr_irq", {31'd0, irq}, 32'd0);
        apb_read(4'h0, v);
        check("mr_status", v, 32'd0);

        // Random byte stream
        apb_write(4'h8, 32'h3);
        m_irq_en = 1'b1;
        for (int n = 0; n < 36; n++) begin
            rb = 8'($urandom);
            if ($urandom_range(0, 3) != 0) rb[3] = 1'b1;
            bp = ($urandom_range(0, 11) == 0);
            bs = ($urandom_range(0, 11) == 1);
            send_byte(rb, bp, bs);
            if ($urandom_range(0, 3) == 0) read_pkt($sformatf("rnd_pkt%0d", n));
            if ($urandom_range(0, 9) == 0) clear(3'($urandom_range(0, 7)));
            check_status($sformatf("rnd_status%0d", n));
        end
        check_irq("rnd_irq");
        clear(3'b111);
        check_status("final_status");
        check_irq("final_irq");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
